// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Stall/flush/sequencing controller for the 5-stage 16-bit RISC
//            pipeline. Handles load-use bubbles, taken-branch flushes, memory
//            back-pressure and LM/SM micro-op sequencing.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int LU_STALL_CYC = 1,
  parameter int NREG         = 8,
  parameter int REG_AW       = 3
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              LOAD_IN_RR,
  input  logic [REG_AW-1:0] RR_DEST_ADD,
  input  logic [REG_AW-1:0] ID_RA_ADD,
  input  logic [REG_AW-1:0] ID_RB_ADD,
  input  logic              ID_USES_RA,
  input  logic              ID_USES_RB,
  input  logic              BR_TAKEN_EX,
  input  logic              MEM_BUSY,
  input  logic              MULTI_START,
  input  logic [NREG-1:0]   MULTI_MASK,
  output logic              PC_EN,
  output logic              IF_ID_EN,
  output logic              IF_ID_CLR,
  output logic              ID_RR_EN,
  output logic              ID_RR_CLR,
  output logic              RR_EX_EN,
  output logic              RR_EX_CLR,
  output logic              MULTI_VALID,
  output logic [REG_AW-1:0] MULTI_REG,
  output logic              MULTI_LAST,
  output logic [1:0]        STATE
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_MULTI = 2'd2
  } state_t;

  // The hazard cycle itself is the first bubble; STALL supplies the rest.
  localparam logic [1:0]      c_STALL_INIT = 2'(LU_STALL_CYC - 1);
  localparam logic [NREG-1:0] c_ONE        = NREG'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_cnt;
  logic [1:0]        w_cnt_nxt;
  logic [NREG-1:0]   r_mask;
  logic [NREG-1:0]   w_mask_nxt;

  logic              w_hazard;
  logic [NREG-1:0]   w_low_onehot;
  logic              w_last;
  logic [REG_AW-1:0] w_low_idx;

  // Load-use detection and lowest-set-bit helpers for the working mask
  always_comb begin
    w_hazard     = LOAD_IN_RR &
                   ((ID_USES_RA & (ID_RA_ADD == RR_DEST_ADD)) |
                    (ID_USES_RB & (ID_RB_ADD == RR_DEST_ADD)));
    w_low_onehot = r_mask & (~r_mask + c_ONE);
    w_last       = (r_mask != '0) && ((r_mask & (r_mask - c_ONE)) == '0);
    w_low_idx    = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (r_mask[i]) w_low_idx = REG_AW'(i);
    end
  end

  // Priority-ordered output decode and next-state selection
  always_comb begin
    PC_EN       = 1'b1;
    IF_ID_EN    = 1'b1;
    ID_RR_EN    = 1'b1;
    RR_EX_EN    = 1'b1;
    IF_ID_CLR   = 1'b0;
    ID_RR_CLR   = 1'b0;
    RR_EX_CLR   = 1'b0;
    MULTI_VALID = 1'b0;
    MULTI_REG   = '0;
    MULTI_LAST  = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;

    if (!RST_N) begin
      PC_EN       = 1'b0;
      IF_ID_EN    = 1'b0;
      ID_RR_EN    = 1'b0;
      RR_EX_EN    = 1'b0;
      IF_ID_CLR   = 1'b1;
      ID_RR_CLR   = 1'b1;
      RR_EX_CLR   = 1'b1;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
      w_mask_nxt  = '0;
    end else if (MEM_BUSY) begin
      // Whole pipe frozen; a branch seen now is re-presented after release.
      PC_EN    = 1'b0;
      IF_ID_EN = 1'b0;
      ID_RR_EN = 1'b0;
      RR_EX_EN = 1'b0;
    end else if (BR_TAKEN_EX) begin
      IF_ID_CLR   = 1'b1;
      ID_RR_CLR   = 1'b1;
      RR_EX_CLR   = 1'b1;
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
      w_mask_nxt  = '0;
    end else begin
      case (r_state)
        ST_STALL: begin
          PC_EN     = 1'b0;
          IF_ID_EN  = 1'b0;
          ID_RR_EN  = 1'b0;
          RR_EX_CLR = 1'b1;
          w_cnt_nxt = r_cnt - 2'd1;
          if (r_cnt <= 2'd1) w_state_nxt = ST_RUN;
        end
        ST_MULTI: begin
          // Front end releases on the final micro-op so the next fetch overlaps it.
          PC_EN       = w_last;
          IF_ID_EN    = w_last;
          ID_RR_EN    = w_last;
          MULTI_VALID = 1'b1;
          MULTI_REG   = w_low_idx;
          MULTI_LAST  = w_last;
          w_mask_nxt  = r_mask & ~w_low_onehot;
          if (w_last || (r_mask == '0)) w_state_nxt = ST_RUN;
        end
        default: begin
          if (w_hazard) begin
            PC_EN     = 1'b0;
            IF_ID_EN  = 1'b0;
            ID_RR_EN  = 1'b0;
            RR_EX_CLR = 1'b1;
            if (LU_STALL_CYC > 1) begin
              w_state_nxt = ST_STALL;
              w_cnt_nxt   = c_STALL_INIT;
            end
          end else if (MULTI_START && (MULTI_MASK != '0)) begin
            PC_EN       = 1'b0;
            IF_ID_EN    = 1'b0;
            ID_RR_EN    = 1'b0;
            w_mask_nxt  = MULTI_MASK;
            w_state_nxt = ST_MULTI;
          end
        end
      endcase
    end
  end

  assign STATE = r_state;

  // State, stall counter and working mask registers
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mask  <= w_mask_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl. Two instances
//            (LU_STALL_CYC=1 and 3) share stimulus; each is compared every
//            cycle with a queue-based behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld, ura, urb, br, busy, ms;
  logic [2:0] dest, ra, rb;
  logic [7:0] mm;

  logic       pc_a, ife_a, ifc_a, ide_a, idc_a, rxe_a, rxc_a, val_a, last_a;
  logic [2:0] reg_a;
  logic [1:0] st_a;
  logic       pc_b, ife_b, ifc_b, ide_b, idc_b, rxe_b, rxc_b, val_b, last_b;
  logic [2:0] reg_b;
  logic [1:0] st_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state per instance: 0 run, 1 stall, 2 multi
  int mode[2], left[2], head[2], npend[2];
  int pend[2][8];
  int bub[2];
  bit bub_on = 1'b0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_STALL_CYC(1), .NREG(8), .REG_AW(3)) u_dut_a (
    .clk(clk), .RST_N(rst_n), .LOAD_IN_RR(ld), .RR_DEST_ADD(dest),
    .ID_RA_ADD(ra), .ID_RB_ADD(rb), .ID_USES_RA(ura), .ID_USES_RB(urb),
    .BR_TAKEN_EX(br), .MEM_BUSY(busy), .MULTI_START(ms), .MULTI_MASK(mm),
    .PC_EN(pc_a), .IF_ID_EN(ife_a), .IF_ID_CLR(ifc_a), .ID_RR_EN(ide_a),
    .ID_RR_CLR(idc_a), .RR_EX_EN(rxe_a), .RR_EX_CLR(rxc_a),
    .MULTI_VALID(val_a), .MULTI_REG(reg_a), .MULTI_LAST(last_a), .STATE(st_a)
  );

  pipe_hazard_ctrl #(.LU_STALL_CYC(3), .NREG(8), .REG_AW(3)) u_dut_b (
    .clk(clk), .RST_N(rst_n), .LOAD_IN_RR(ld), .RR_DEST_ADD(dest),
    .ID_RA_ADD(ra), .ID_RB_ADD(rb), .ID_USES_RA(ura), .ID_USES_RB(urb),
    .BR_TAKEN_EX(br), .MEM_BUSY(busy), .MULTI_START(ms), .MULTI_MASK(mm),
    .PC_EN(pc_b), .IF_ID_EN(ife_b), .IF_ID_CLR(ifc_b), .ID_RR_EN(ide_b),
    .ID_RR_CLR(idc_b), .RR_EX_EN(rxe_b), .RR_EX_CLR(rxc_b),
    .MULTI_VALID(val_b), .MULTI_REG(reg_b), .MULTI_LAST(last_b), .STATE(st_b)
  );

  wire [10:0] obs_a = {pc_a, ife_a, ifc_a, ide_a, idc_a, rxe_a, rxc_a, val_a, last_a, st_a};
  wire [10:0] obs_b = {pc_b, ife_b, ifc_b, ide_b, idc_b, rxe_b, rxc_b, val_b, last_b, st_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] pk(input logic pc, ife, ifc, ide, idc, rxe, rxc, v, l,
                                     input logic [1:0] s);
    return {pc, ife, ifc, ide, idc, rxe, rxc, v, l, s};
  endfunction

  // Expected outputs for instance k from the current inputs, then advance the model
  task automatic model(input int k, input int lu, output logic [10:0] e,
                       output logic [10:0] care, output logic [2:0] ereg, output bit regcare);
    logic [1:0] s;
    bit hz, last;
    s       = 2'(mode[k]);
    care    = 11'h7FF;
    ereg    = 3'd0;
    regcare = 1'b0;
    hz = ld && ((ura && ra == dest) || (urb && rb == dest));
    if (!rst_n) begin
      e = pk(0, 0, 1, 0, 1, 0, 1, 0, 0, 2'd0);
      regcare = 1'b1;
      mode[k] = 0; left[k] = 0; head[k] = 0; npend[k] = 0;
    end else if (busy) begin
      e = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, s);
      care[2] = 1'b0;
    end else if (br) begin
      e = pk(1, 0, 1, 0, 1, 1, 1, 0, 0, s);
      care[9] = 1'b0; care[7] = 1'b0; care[2] = 1'b0;
      mode[k] = 0; left[k] = 0; head[k] = 0; npend[k] = 0;
    end else if (mode[k] == 1) begin
      e = pk(0, 0, 0, 0, 0, 0, 1, 0, 0, s);
      care[5] = 1'b0;
      left[k]--;
      if (left[k] == 0) mode[k] = 0;
    end else if (mode[k] == 2) begin
      last = (npend[k] - head[k]) == 1;
      e = pk(last, last, 0, last, 0, 1, 0, 1, last, s);
      ereg = 3'(pend[k][head[k]]);
      regcare = 1'b1;
      head[k]++;
      if (head[k] == npend[k]) mode[k] = 0;
    end else if (hz) begin
      e = pk(0, 0, 0, 0, 0, 0, 1, 0, 0, s);
      care[5] = 1'b0;
      if (lu > 1) begin mode[k] = 1; left[k] = lu - 1; end
    end else if (ms && mm != 8'd0) begin
      e = pk(0, 0, 0, 0, 0, 1, 0, 0, 0, s);
      npend[k] = 0; head[k] = 0;
      for (int i = 0; i < 8; i++) if (mm[i]) begin pend[k][npend[k]] = i; npend[k]++; end
      mode[k] = 2;
    end else begin
      e = pk(1, 1, 0, 1, 0, 1, 0, 0, 0, s);
    end
  endtask

  // Check both instances against the model at the current inputs, then clock once
  task automatic step();
    logic [10:0] e, care, o;
    logic [2:0]  ereg, oreg;
    bit          rc;
    #2;
    for (int k = 0; k < 2; k++) begin
      o    = (k == 0) ? obs_a : obs_b;
      oreg = (k == 0) ? reg_a : reg_b;
      model(k, (k == 0) ? 1 : 3, e, care, ereg, rc);
      check($sformatf("lu%0d.ctl", (k == 0) ? 1 : 3), 32'(o & care), 32'(e & care));
      if (rc) check($sformatf("lu%0d.reg", (k == 0) ? 1 : 3), 32'(oreg), 32'(ereg));
      if (bub_on && !o[10] && o[4]) bub[k]++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; ld = 0; ura = 0; urb = 0; br = 0; busy = 0; ms = 0;
    dest = 0; ra = 0; rb = 0; mm = 0;
  endtask

  task automatic rand_inputs();
    ld   = ($urandom_range(0, 9) < 3);
    dest = 3'($urandom_range(0, 3));
    ra   = 3'($urandom_range(0, 3));
    rb   = 3'($urandom_range(0, 3));
    ura  = 1'($urandom_range(0, 1));
    urb  = 1'($urandom_range(0, 1));
    br   = ($urandom_range(0, 9) == 0);
    busy = ($urandom_range(0, 6) == 0);
    ms   = ($urandom_range(0, 4) == 0);
    mm   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
  endtask

  task automatic idle_n(input int n);
    idle();
    for (int i = 0; i < n; i++) step();
  endtask

  // Stimulus: directed scenarios followed by randomized traffic
  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0; left[k] = 0; head[k] = 0; npend[k] = 0; bub[k] = 0;
    end
    idle();
    // Reset held three cycles with random inputs, then release
    for (int i = 0; i < 3; i++) begin rand_inputs(); rst_n = 1'b0; step(); end
    idle_n(2);

    // Load-use on RA: 1 bubble for LU=1, 3 bubbles for LU=3
    bub_on = 1'b1;
    idle(); ld = 1; dest = 3'd3; ra = 3'd3; ura = 1; step();
    idle_n(5);
    bub_on = 1'b0;
    check("lu1.bubbles", 32'(bub[0]), 32'd1);
    check("lu3.bubbles", 32'(bub[1]), 32'd3);

    // Load-use on RB, not RA
    idle(); ld = 1; dest = 3'd6; rb = 3'd6; urb = 1; ra = 3'd6; step();
    idle_n(4);

    // LM sequencing with mask 1010_0101
    idle(); ms = 1; mm = 8'hA5; step();
    idle_n(6);

    // Branch abort during the second micro-op
    idle(); ms = 1; mm = 8'hA5; step();
    idle(); step();
    br = 1; step();
    idle_n(3);

    // Memory back-pressure mid-MULTI with a branch pulse while busy
    idle(); ms = 1; mm = 8'h06; step();
    idle(); busy = 1; step();
    br = 1; step();
    br = 0; step(); step();
    idle_n(4);

    // Zero mask with MULTI_START behaves as a plain instruction
    idle(); ms = 1; mm = 8'h00; step();
    idle_n(2);

    // Reset asserted mid-sequence
    idle(); ms = 1; mm = 8'hFF; step();
    idle(); step(); step();
    rst_n = 1'b0; step();
    idle_n(3);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    idle_n(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/sequencing controller for the 5-stage 16-bit RISC pipeline.
- Drives the enable and clear inputs of the PC, IF_ID, ID_RR and RR_EX pipeline registers.
- Resolves load-use hazards, taken-branch flushes and memory back-pressure.
- Sequences LM/SM multi-register instructions as one register index per cycle while the front end is frozen.

Parameters:
- LU_STALL_CYC, 1: bubbles inserted per load-use hazard; legal range 1..3.
- NREG, 8: architectural register count; MULTI_MASK width.
- REG_AW, 3: register address width, equal to log2(NREG).

Ports:
- clk  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- LOAD_IN_RR  in  1  the instruction in RR stage is LW or LM
- RR_DEST_ADD  in  REG_AW  destination of that load
- ID_RA_ADD  in  REG_AW  RA source of the instruction in ID stage
- ID_RB_ADD  in  REG_AW  RB source of the instruction in ID stage
- ID_USES_RA  in  1  the ID instruction reads RA
- ID_USES_RB  in  1  the ID instruction reads RB
- BR_TAKEN_EX  in  1  branch/jump redirect resolved in EX this cycle
- MEM_BUSY  in  1  data memory not ready; freeze the pipeline
- MULTI_START  in  1  LM/SM decoded in ID stage
- MULTI_MASK  in  NREG  register list of that LM/SM
- PC_EN  out  1  PC load enable
- IF_ID_EN  out  1  IF_ID register enable
- IF_ID_CLR  out  1  IF_ID clear
- ID_RR_EN  out  1  ID_RR register enable
- ID_RR_CLR  out  1  ID_RR clear
- RR_EX_EN  out  1  RR_EX register enable
- RR_EX_CLR  out  1  RR_EX clear (bubble insertion)
- MULTI_VALID  out  1  MULTI_REG is valid this cycle
- MULTI_REG  out  REG_AW  register index of the current LM/SM micro-op
- MULTI_LAST  out  1  final micro-op of the current LM/SM
- STATE  out  2  debug: 0 RUN, 1 STALL, 2 MULTI

Behaviour:
- State, stall counter (2 bits) and working mask (NREG bits) are registers. All other outputs are combinational from state, working mask and inputs.
- While RST_N=0:
  - state=RUN, counter=0, working mask=0.
  - All *_EN=0, all *_CLR=1, MULTI_VALID=0, MULTI_REG=0, MULTI_LAST=0.
- Priority each cycle: MEM_BUSY > BR_TAKEN_EX > current STALL/MULTI sequence > load-use detect > MULTI_START.
- MEM_BUSY=1:
  - All *_EN=0, all *_CLR=0.
  - State, counter and mask hold; BR_TAKEN_EX is ignored (EX is frozen, so it is re-sampled later).
  - MULTI_VALID is forced 0.
- BR_TAKEN_EX=1:
  - PC_EN=1, IF_ID_CLR=1, ID_RR_CLR=1, RR_EX_CLR=1, RR_EX_EN=1.
  - Any STALL or MULTI sequence is aborted: next state=RUN, counter=0, mask=0.
- RUN, no event: all *_EN=1, all *_CLR=0.
- Load-use hazard:
  - Condition: LOAD_IN_RR & ((ID_USES_RA & ID_RA_ADD==RR_DEST_ADD) | (ID_USES_RB & ID_RB_ADD==RR_DEST_ADD)).
  - In RUN, this cycle: PC_EN=0, IF_ID_EN=0, ID_RR_EN=0, RR_EX_CLR=1.
  - If LU_STALL_CYC>1: go to STALL with counter=LU_STALL_CYC-1.
- STALL:
  - Same outputs as the hazard cycle; counter decrements.
  - At counter=1 the next state is RUN.
  - Total bubbles inserted = LU_STALL_CYC exactly.
- MULTI_START in RUN, no hazard, MULTI_MASK≠0:
  - Entry cycle: PC_EN=0, IF_ID_EN=0, ID_RR_EN=0, RR_EX_EN=1.
  - Latch MULTI_MASK into the working mask; next state=MULTI.
- MULTI_START with MULTI_MASK=0: treated as a normal instruction (NOP); no MULTI entry.
- MULTI:
  - MULTI_VALID=1; MULTI_REG = lowest set bit index of the working mask.
  - The working mask clears that bit each cycle.
  - PC_EN, IF_ID_EN and ID_RR_EN stay 0; RR_EX_EN=1, RR_EX_CLR=0.
  - MULTI_LAST=1 when exactly one bit remains. That cycle ID_RR_EN=IF_ID_EN=PC_EN=1 and next state=RUN.
  - A mask with n set bits gives n micro-op cycles plus 1 entry cycle.
- The load-use condition is not evaluated in MULTI or STALL; it is re-evaluated on return to RUN.
- Reset asserted mid-sequence: immediate return to reset outputs and state.

Test Plan:
- Reset: RST_N=0 for 3 cycles with random inputs -> all *_EN=0, all *_CLR=1, STATE=0. Release -> all *_EN=1 on the first clock.
- Load-use, LU_STALL_CYC=1: LOAD_IN_RR=1, RR_DEST_ADD=3, ID_RA_ADD=3, ID_USES_RA=1 -> exactly 1 cycle with PC_EN=IF_ID_EN=ID_RR_EN=0 and RR_EX_CLR=1. Rerun with LU_STALL_CYC=3 -> exactly 3 such cycles.
- LM sequencing: MULTI_MASK=8'b1010_0101 -> 1 entry cycle, then MULTI_REG=0,2,5,7 on consecutive cycles with MULTI_LAST only on 7. The front-end enables return to 1 on the 7 cycle.
- Branch abort: BR_TAKEN_EX=1 during the second MULTI micro-op -> IF_ID_CLR=ID_RR_CLR=RR_EX_CLR=1, PC_EN=1; next cycle STATE=0 and MULTI_VALID=0.
- MEM_BUSY=1 for 4 cycles mid-MULTI (mask 8'b0000_0110) with BR_TAKEN_EX pulsed during busy -> outputs frozen, no flush. After release, MULTI_REG resumes from the held index.
- MULTI_MASK=0 with MULTI_START=1 -> no stall, STATE stays 0, MULTI_VALID=0.
